// File: rtl/tmu2dac_if.sv
// Sample-pair handshake between the TMU PID stage and the DAC serialiser.
// The master presents both control words with in_valid; the slave answers with in_ready.
interface tmu2dac_if #(
    parameter int IN_W = 16
) ();
    logic signed [IN_W-1:0] pid_out1_in;
    logic signed [IN_W-1:0] pid_out2_in;
    logic                   in_valid;
    logic                   in_ready;

    modport master (
        output pid_out1_in,
        output pid_out2_in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  pid_out1_in,
        input  pid_out2_in,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/tmu2dac.sv
// Dual-channel 12-bit serial DAC driver: saturates two signed PID words to offset
// binary and ships them as two 16-bit frames (channel 0 first) over sclk/sync_n/sdin.
module tmu2dac #(
    parameter int IN_W    = 16,
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rstn,
    tmu2dac_if.slave   bus,
    output logic       dac_sclk,
    output logic       dac_sync_n,
    output logic       dac_sdin,
    output logic [1:0] sat_flag
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    localparam logic signed [IN_W-1:0] POS_LIM = IN_W'(2047);
    localparam logic signed [IN_W-1:0] NEG_LIM = IN_W'(-2048);

    logic signed [IN_W-1:0] pid_word  [2];
    logic        [11:0]     code_next [2];
    logic        [1:0]      sat_next;

    logic [1:0]       state_reg;
    logic             ch_reg;
    logic [11:0]      code_reg [2];
    logic [1:0]       sat_reg;
    logic [15:0]      shift_reg;
    logic [DIV_W-1:0] div_reg;
    logic [3:0]       bit_reg;
    logic [GAP_W-1:0] gap_reg;
    logic             sclk_reg;
    logic             sync_n_reg;
    logic [15:0]      frame;

    assign pid_word[0] = bus.pid_out1_in;
    assign pid_word[1] = bus.pid_out2_in;

    // Offset binary of an in-range word is its low 12 bits with the MSB flipped.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_conv
            assign sat_next[gi]  = (pid_word[gi] > POS_LIM) || (pid_word[gi] < NEG_LIM);
            assign code_next[gi] = (pid_word[gi] > POS_LIM) ? 12'hFFF :
                                   (pid_word[gi] < NEG_LIM) ? 12'h000 :
                                   {~pid_word[gi][11], pid_word[gi][10:0]};
        end
    endgenerate

    // Frame: {0, channel, write+update, code}.
    assign frame = {1'b0, ch_reg, 2'b01, code_reg[ch_reg]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            ch_reg      <= 1'b0;
            code_reg[0] <= 12'h000;
            code_reg[1] <= 12'h000;
            sat_reg     <= 2'b00;
            shift_reg   <= 16'h0000;
            div_reg     <= '0;
            bit_reg     <= 4'd0;
            gap_reg     <= '0;
            sclk_reg    <= 1'b0;
            sync_n_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        code_reg[0] <= code_next[0];
                        code_reg[1] <= code_next[1];
                        sat_reg     <= sat_next;
                        ch_reg      <= 1'b0;
                        state_reg   <= LOAD;
                    end
                end
                LOAD: begin
                    shift_reg  <= frame;
                    sync_n_reg <= 1'b0;
                    sclk_reg   <= 1'b0;
                    div_reg    <= '0;
                    bit_reg    <= 4'd0;
                    state_reg  <= SHIFT;
                end
                SHIFT: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg <= '0;
                        if (!sclk_reg) begin
                            sclk_reg <= 1'b1;
                        end else begin
                            sclk_reg <= 1'b0;
                            // The 16th falling edge closes the frame; sdin returns low with sync_n.
                            if (bit_reg == 4'd15) begin
                                shift_reg  <= 16'h0000;
                                sync_n_reg <= 1'b1;
                                gap_reg    <= '0;
                                state_reg  <= GAP;
                            end else begin
                                shift_reg <= {shift_reg[14:0], 1'b0};
                                bit_reg   <= bit_reg + 4'd1;
                            end
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
                default: begin
                    if (gap_reg == GAP_LAST) begin
                        if (!ch_reg) begin
                            ch_reg    <= 1'b1;
                            state_reg <= LOAD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready = (state_reg == IDLE);
    assign dac_sclk     = sclk_reg;
    assign dac_sync_n   = sync_n_reg;
    assign dac_sdin     = shift_reg[15];
    assign sat_flag     = sat_reg;

endmodule
